uart_rx_fifo: RTL

Receive front end for the fmrv32im SoC UART on Arty A7. Sits between the board pin `uart_txd_in` and the SoC's UART receive path: synchronises the asynchronous serial line, decodes 8N1 frames with 16x oversampling, and buffers received bytes in a first-word-fall-through FIFO drained by a valid/ready handshake. Error conditions are reported as sticky flags cleared by software.

---
 rtl/uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front end. Synchronises RXD, decodes frames with
// 16x oversampling and buffers bytes in a first-word-fall-through FIFO drained
// by a valid/ready handshake. Error conditions are sticky flags cleared by ERR_CLR.
// Build option: define UART_RX_PARITY_EN for 8E1 frames (parity state and
// PAR_ERR active); otherwise frames are 8N1 and PAR_ERR is tied to 0.
module uart_rx_fifo #(
  parameter int unsigned BAUD_DIV   = 54,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RXD,
  output logic [7:0]                    RDATA,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  output logic                          PAR_ERR,
  input  logic                          ERR_CLR
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0] TickMax   = TW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FullLevel = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // Line synchroniser and edge detect
  logic sync1_q, sync2_q, sync3_q;
  logic rx, fall;

  // Receiver state
  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    os_cnt_q, os_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push, frame_set;

  // FIFO and flags
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, full, wr_en, ovr_set;
  logic          frame_err_q, frame_err_d, overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, par_set;
  logic par_err_q, par_err_d;
`endif

  // Two-flop synchroniser plus a third stage for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx   = sync2_q;
  assign fall = sync3_q & ~sync2_q;
  assign tick = (tick_cnt_q == TickMax);

  // Frame decoder next-state: tick divider, oversample count, bit capture
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_set    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // Only an edge starts a frame, so a stuck-low line cannot retrigger
        if (fall) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          os_cnt_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d = '0;
            if (rx) begin
              state_d = StIdle;
            end else begin
              state_d   = StData;
              bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            os_cnt_d = '0;
            shift_d  = {rx, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            os_cnt_d  = '0;
            par_bad_d = (rx != ^shift_q);
            state_d   = StStop;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (os_cnt_q == 4'd15) begin
            os_cnt_d = '0;
            state_d  = StIdle;
            if (!rx) begin
              frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              par_set = 1'b1;
`endif
            end else begin
              push = 1'b1;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop     = RVALID & RREADY;
  assign full    = (count_q == FullLevel);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  // FIFO pointer/count and sticky flag next-state; a set beats a clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    frame_err_d = frame_set | (frame_err_q & ~ERR_CLR);
    overrun_d   = ovr_set | (overrun_q & ~ERR_CLR);
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_set | (par_err_q & ~ERR_CLR);
`endif
  end

  // State registers with synchronous reset; reset drops any partial frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  assign RVALID    = (count_q != '0);
  assign RDATA     = RVALID ? mem[rd_ptr_q] : 8'h00;
  assign LEVEL     = count_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign PAR_ERR   = par_err_q;
`else
  assign PAR_ERR   = 1'b0;
`endif

endmodule
